// File: rtl/dffr_pkg.sv
// dffr_pkg: shared mode encodings for the dffr register family
package dffr_pkg;
  localparam int USHREG_MODE_W = 3;
  typedef enum logic [USHREG_MODE_W-1:0] {
    HOLD = 3'b000,
    SHL  = 3'b001,
    SHR  = 3'b010,
    LOAD = 3'b011,
    ROL  = 3'b100,
    ROR  = 3'b101,
    CLR  = 3'b110,
    INV  = 3'b111
  } ushreg_mode_t;
endpackage

// File: rtl/dffr_bank.sv
// dffr_bank: WIDTH-bit register with asynchronous active-high reset to a per-instance value
module dffr_bank #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // capture d each edge; reset overrides asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RST_VAL;
    else q <= d;
endmodule

// File: rtl/dffr_ushreg.sv
// dffr_ushreg: universal shift register with registered q/q_ outputs; DFFR_USHREG_PARITY_EN adds registered parity output par
module dffr_ushreg import dffr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [USHREG_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]         d,
  input  logic                     sin_l,
  input  logic                     sin_r,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_,
  output logic                     sout_l,
  output logic                     sout_r
`ifdef DFFR_USHREG_PARITY_EN
  ,
  output logic                     par
`endif
);
  logic [WIDTH-1:0] q_next;
  // next-state selection; undefined mode encodings fall through to hold
  always_comb begin
    q_next = q;
    if (en)
      case (ushreg_mode_t'(mode))
        SHL:     q_next = {q[WIDTH-2:0], sin_l};
        SHR:     q_next = {sin_r, q[WIDTH-1:1]};
        LOAD:    q_next = d;
        ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        ROR:     q_next = {q[0], q[WIDTH-1:1]};
        CLR:     q_next = RST_VAL;
        INV:     q_next = ~q;
        default: q_next = q;
      endcase
  end
  dffr_bank #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_q (
    .clk(clk), .rst(rst), .d(q_next), .q(q)
  );
  dffr_bank #(.WIDTH(WIDTH), .RST_VAL(~RST_VAL)) u_qn (
    .clk(clk), .rst(rst), .d(~q_next), .q(q_)
  );
`ifdef DFFR_USHREG_PARITY_EN
  dffr_bank #(.WIDTH(1), .RST_VAL(^RST_VAL)) u_par (
    .clk(clk), .rst(rst), .d(^q_next), .q(par)
  );
`endif
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
endmodule

// File: tb/tb_dffr_ushreg.sv
// tb_dffr_ushreg: scoreboard bench for dffr_ushreg (WIDTH=8, RST_VAL=8'hA5)
module tb_dffr_ushreg;
  localparam logic [7:0] RV = 8'hA5;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sin_l = 1'b0, sin_r = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = 8'h00, q, q_;
  logic sout_l, sout_r;
`ifdef DFFR_USHREG_PARITY_EN
  logic par;
`endif
  int total = 0, bad = 0;
  logic [7:0] sb[$];
  logic [7:0] m = RV, e;

  dffr_ushreg #(.WIDTH(8), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .q(q), .q_(q_), .sout_l(sout_l), .sout_r(sout_r)
`ifdef DFFR_USHREG_PARITY_EN
    , .par(par)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(input logic [7:0] c, input logic e_, input logic [2:0] md,
                                       input logic [7:0] dd, input logic sl, input logic sr);
    if (!e_) return c;
    case (md)
      3'd1: return (c << 1) | 8'(sl);
      3'd2: return (c >> 1) | (8'(sr) << 7);
      3'd3: return dd;
      3'd4: return (c << 1) | (c >> 7);
      3'd5: return (c >> 1) | (c << 7);
      3'd6: return RV;
      3'd7: return c ^ 8'hFF;
      default: return c;
    endcase
  endfunction

  task automatic tick(input logic e_, input logic [2:0] md, input logic [7:0] dd,
                      input logic sl, input logic sr);
    en = e_; mode = md; d = dd; sin_l = sl; sin_r = sr;
    m = model(m, e_, md, dd, sl, sr);
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (q !== RV || q_ !== ~RV) begin bad++; $display("FAIL reset_init: q=%h q_=%h want %h %h", q, q_, RV, ~RV); end
    total++;
    if (sout_l !== 1'b1 || sout_r !== 1'b1) begin bad++; $display("FAIL reset_sout: l=%b r=%b want 1 1", sout_l, sout_r); end
`ifdef DFFR_USHREG_PARITY_EN
    total++;
    if (par !== 1'b0) begin bad++; $display("FAIL reset_par: par=%b want 0", par); end
`endif
    rst = 1'b0;
    m = RV;
    tick(1, 3'd3, 8'h3C, 0, 0);
    e = sb.pop_front();
    total++;
    if (q !== 8'h3C || q !== e || q_ !== 8'hC3) begin bad++; $display("FAIL load_3c: q=%h q_=%h want 3c c3", q, q_); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (q !== RV || q_ !== 8'h5A) begin bad++; $display("FAIL reset_async: q=%h q_=%h want a5 5a", q, q_); end
    #2 rst = 1'b0;
    m = RV;
  endtask

  task automatic test_shift;
    tick(1, 3'd3, 8'h81, 0, 0);
    e = sb.pop_front();
    total++;
    if (q !== e || sout_l !== 1'b1 || sout_r !== 1'b1) begin bad++; $display("FAIL shl_pre: q=%h l=%b r=%b want 81 1 1", q, sout_l, sout_r); end
    tick(1, 3'd1, 8'h00, 1, 0);
    e = sb.pop_front();
    total++;
    if (q !== 8'h03 || q !== e || q_ !== ~e || sout_l !== 1'b0) begin bad++; $display("FAIL shl: q=%h q_=%h l=%b want 03 fc 0", q, q_, sout_l); end
    tick(1, 3'd2, 8'h00, 0, 1);
    e = sb.pop_front();
    total++;
    if (q !== 8'h81 || q !== e || q_ !== ~e) begin bad++; $display("FAIL shr: q=%h want 81", q); end
    tick(1, 3'd4, 8'h00, 0, 0);
    e = sb.pop_front();
    total++;
    if (q !== 8'h03 || q !== e) begin bad++; $display("FAIL rol: q=%h want 03", q); end
  endtask

  task automatic test_rotate;
    logic [7:0] w;
    tick(1, 3'd3, 8'h01, 0, 0);
    e = sb.pop_front();
    w = 8'h01;
    for (int i = 0; i < 8; i++) begin
      tick(1, 3'd5, 8'h00, 0, 0);
      e = sb.pop_front();
      w = {w[0], w[7:1]};
      total++;
      if (q !== e || q !== w || q_ !== ~w) begin bad++; $display("FAIL ror_%0d: q=%h want %h", i, q, w); end
    end
    total++;
    if (q !== 8'h01) begin bad++; $display("FAIL ror_wrap: q=%h want 01", q); end
  endtask

  task automatic test_enable;
    logic [7:0] h;
    h = m;
    tick(0, 3'd3, 8'hFF, 0, 0);
    e = sb.pop_front();
    total++;
    if (q !== h || q !== e || q_ !== ~h) begin bad++; $display("FAIL en_hold: q=%h want %h", q, h); end
    tick(1, 3'd3, 8'h5F, 0, 0);
    e = sb.pop_front();
    en = 1'b1; mode = 3'd1; sin_l = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if (q !== RV || q_ !== ~RV) begin bad++; $display("FAIL rst_mid: q=%h want a5", q); end
    @(posedge clk);
    #1;
    total++;
    if (q !== RV || q_ !== ~RV) begin bad++; $display("FAIL rst_edge: q=%h want a5", q); end
    #2 rst = 1'b0;
    m = RV;
    tick(1, 3'd0, 8'h00, 0, 0);
    e = sb.pop_front();
    total++;
    if (q !== RV || q !== e) begin bad++; $display("FAIL rst_release_hold: q=%h want a5", q); end
  endtask

  task automatic test_clr_inv;
    tick(1, 3'd3, 8'h0F, 0, 0);
    e = sb.pop_front();
    tick(1, 3'd7, 8'h00, 0, 0);
    e = sb.pop_front();
    total++;
    if (q !== 8'hF0 || q !== e || q_ !== 8'h0F) begin bad++; $display("FAIL inv: q=%h q_=%h want f0 0f", q, q_); end
    tick(1, 3'd6, 8'h00, 0, 0);
    e = sb.pop_front();
    total++;
    if (q !== RV || q !== e || q_ !== ~RV) begin bad++; $display("FAIL clr: q=%h want a5", q); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) begin
      tick($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom));
      e = sb.pop_front();
      total++;
      if (q !== e || q_ !== ~e || sout_l !== e[7] || sout_r !== e[0]) begin
        bad++; $display("FAIL rand_%0d: q=%h q_=%h l=%b r=%b want %h %h", i, q, q_, sout_l, sout_r, e, ~e);
      end
`ifdef DFFR_USHREG_PARITY_EN
      total++;
      if (par !== ^e) begin bad++; $display("FAIL rand_par_%0d: par=%b want %b", i, par, ^e); end
`endif
    end
  endtask

`ifdef DFFR_USHREG_PARITY_EN
  task automatic test_parity;
    tick(1, 3'd3, 8'h07, 0, 0);
    e = sb.pop_front();
    total++;
    if (par !== 1'b1 || q !== e) begin bad++; $display("FAIL par_07: par=%b q=%h want 1 07", par, q); end
    tick(1, 3'd7, 8'h00, 0, 0);
    e = sb.pop_front();
    total++;
    if (par !== 1'b1 || q !== 8'hF8) begin bad++; $display("FAIL par_f8: par=%b q=%h want 1 f8", par, q); end
    tick(1, 3'd3, 8'h03, 0, 0);
    e = sb.pop_front();
    total++;
    if (par !== 1'b0 || q !== e) begin bad++; $display("FAIL par_03: par=%b q=%h want 0 03", par, q); end
  endtask
`endif

  initial begin
    test_reset;
    test_shift;
    test_rotate;
    test_enable;
    test_clr_inv;
`ifdef DFFR_USHREG_PARITY_EN
    test_parity;
`endif
    test_random;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dffr_ushreg.md
Name: dffr_ushreg

Overview:
- Parametrised universal shift register; successor to the single-bit reset flop cell in the cells library.
- WIDTH-bit register with registered true and complement outputs (q, q_).
- Supports hold, shift, rotate, parallel load, synchronous clear and invert.
- Used as a building block for serialisers, LFSR seeds and scan-style register chains.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on asynchronous reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  clock enable; 0 = hold regardless of mode
- mode  in  3  operation select (encodings below)
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial input entering the LSB on shift-left
- sin_r  in  1  serial input entering the MSB on shift-right
- q  out  WIDTH  register contents
- q_  out  WIDTH  bitwise complement of q, registered, not derived combinationally
- sout_l  out  1  q[WIDTH-1] (bit leaving on shift-left)
- sout_r  out  1  q[0] (bit leaving on shift-right)

Behaviour:
- Reset: rst=1 forces, asynchronously and independently of clk:
  - q=RST_VAL, q_=~RST_VAL
  - sout_l=RST_VAL[WIDTH-1], sout_r=RST_VAL[0]
- Reset release: deassertion is synchronised by the consumer; the first active edge after release applies normal operation.
- Reset mid-operation: any in-flight shift is discarded; no partial update.
- Update rule: all updates occur on the rising clk edge, one-cycle latency from inputs to q.
- Priority: rst > en=0 (hold) > mode.
- Mode encodings:
  - 3'b000 HOLD: q unchanged
  - 3'b001 SHL: q = {q[WIDTH-2:0], sin_l}
  - 3'b010 SHR: q = {sin_r, q[WIDTH-1:1]}
  - 3'b011 LOAD: q = d
  - 3'b100 ROL: q = {q[WIDTH-2:0], q[WIDTH-1]}
  - 3'b101 ROR: q = {q[0], q[WIDTH-1:1]}
  - 3'b110 CLR: q = RST_VAL (synchronous)
  - 3'b111 INV: q = ~q
- Complement output: q_ is a separate register loaded with the complement of q's next value. The invariant q_==~q holds at every cycle, including immediately after reset.
- Serial outputs: sout_l and sout_r are combinational taps of registered q (no extra latency), so they present the bit that the next shift will discard.
- Boundaries:
  - WIDTH=2: shifts and rotates remain well-defined.
  - Rotate by WIDTH consecutive cycles returns the original value.
  - X or Z on mode while en=1 is a bench-flagged error; the RTL treats undefined encodings as HOLD.

Optional Feature:
- Macro: DFFR_USHREG_PARITY_EN.
- Defined:
  - Adds output port par (1 bit), a registered even parity of q: par = ^q_next.
  - Updates in the same cycle as q.
  - Reset value is ^RST_VAL.
- Undefined: the par port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package dffr_pkg holds:
  - mode enum type ushreg_mode_t (HOLD, SHL, SHR, LOAD, ROL, ROR, CLR, INV), 3 bits
  - constant USHREG_MODE_W=3
- One sub-module is natural: dffr_bank, a WIDTH-bit async-reset (active-high) register with per-instance reset value.
  - Instantiated twice: once for q, once for q_ with reset value ~RST_VAL.
  - The top holds only the next-state mux.

Test Plan:
- Reset and load: rst=1 mid-cycle, WIDTH=8, RST_VAL=8'hA5 -> q=8'hA5 and q_=8'h5A immediately, without a clock edge. Then LOAD d=8'h3C -> q=8'h3C, q_=8'hC3 after one edge.
- Shift left: q=8'h81, SHL with sin_l=1 -> q=8'h03, sout_l=0 afterwards. sout_l was 1 before the edge.
- Rotate: q=8'h01, ROR 8 cycles -> q steps through 8'h80, 8'h40, …, and equals 8'h01 again after cycle 8.
- Enable gating and priority: en=0 with mode=LOAD d=8'hFF -> q unchanged. Assert rst while en=1 mode=SHL -> q=RST_VAL, and the shift is lost.
- CLR and INV: q=8'h0F, INV -> 8'hF0. Then CLR -> RST_VAL. Check q_==~q on every cycle of a random 1000-cycle mode sequence.
- Parity (DFFR_USHREG_PARITY_EN): LOAD 8'h07 -> par=1. INV -> q=8'hF8, par=1. LOAD 8'h03 -> par=0.
